// File: rtl/dxi_pkg.sv
// rtl/dxi_pkg.sv - shared pixel/window types for the DXI window path
package dxi_pkg;

  localparam int PIX_W   = 8;
  localparam int WIN_PIX = 9;
  localparam int WIN_W   = WIN_PIX * PIX_W;

  typedef logic [PIX_W-1:0] pixel_t;

  // Index 0 is top-left, raster order, index 8 is bottom-right
  typedef pixel_t [0:WIN_PIX-1] window_t;

  // Flatten a window so that index 0 lands in the most significant byte
  function automatic logic [WIN_W-1:0] pack_window(input window_t w);
    logic [WIN_W-1:0] v;
    v = '0;
    for (int i = 0; i < WIN_PIX; i++) begin
      v[WIN_W-1-PIX_W*i -: PIX_W] = w[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/dxi_line_buffer.sv
// rtl/dxi_line_buffer.sv - single-port line store with combinational read-before-write
module dxi_line_buffer #(
  parameter int DEPTH = 640,
  parameter int PIX_W = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [PIX_W-1:0] i_wdata,
  output logic [PIX_W-1:0] o_rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Read is unregistered, so the cycle that writes an address still sees the old pixel
  assign o_rdata = mem[i_addr];

  // Contents carry no reset; rows are only trusted once the row counter says they are filled
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/dxi_window_gen.sv
// rtl/dxi_window_gen.sv - 3x3 sliding window generator over a raster pixel stream
module dxi_window_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_dxi_valid,
  input  logic [PIX_W-1:0]   i_dxi_data,
  input  logic               i_dxi_sof,
  output logic               o_dxi_ready,
  output logic               o_dxi_out_valid,
  output logic [9*PIX_W-1:0] o_dxi_out_data,
  input  logic               i_dxi_out_ready
);

  import dxi_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic          rst_meta_q;
  logic          rst_sync_q;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  window_t       win_q, win_d;
  logic          out_valid_q, out_valid_d;
  logic [WIN_W-1:0] out_data_q, out_data_d;

  logic [CW-1:0] col_eff;
  logic [RW-1:0] row_eff;
  logic          accept;
  logic          emit;
  pixel_t        lb0_rd;
  pixel_t        lb1_rd;

  // Reset asserts immediately and releases only after two clean clock edges
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // Input may advance whenever the output slot is empty or being drained this cycle
  assign o_dxi_ready = !out_valid_q || i_dxi_out_ready;
  assign accept      = i_dxi_valid && o_dxi_ready;

  // An SOF beat is treated as position (0,0) regardless of where the counters were
  always_comb begin
    col_eff = i_dxi_sof ? '0 : col_q;
    row_eff = i_dxi_sof ? '0 : row_q;
    emit    = accept && (row_eff >= RW'(2)) && (col_eff >= CW'(2));
  end

  // lb0 holds the previous row, lb1 the row before that; both shift down on accept
  dxi_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb0 (
    .i_clk   (i_clk),
    .i_we    (accept),
    .i_addr  (col_eff),
    .i_wdata (i_dxi_data),
    .o_rdata (lb0_rd)
  );

  dxi_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb1 (
    .i_clk   (i_clk),
    .i_we    (accept),
    .i_addr  (col_eff),
    .i_wdata (lb0_rd),
    .o_rdata (lb1_rd)
  );

  // Raster position tracking: column wraps into the row counter, row wraps at frame end
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_eff == COL_LAST) begin
        col_d = '0;
        row_d = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
        row_d = row_eff;
      end
    end
  end

  // Shift the window one column left and load {two rows up, one row up, new pixel} on the right
  always_comb begin
    win_d = win_q;
    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb1_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb0_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = i_dxi_data;
    end
  end

  // Output slot: load a fresh window, otherwise empty it once the consumer takes it
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = pack_window(win_d);
    end else if (out_valid_q && i_dxi_out_ready) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end
  end

  // State registers, cleared by the synchronised reset
  always_ff @(posedge i_clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign o_dxi_out_valid = out_valid_q;
  assign o_dxi_out_data  = out_data_q;

endmodule
